// File: rtl/spi_pkg.sv
// Shared definitions for the SPI transmit feeder: register map, STATUS layout
// and the export FSM state encoding.
package spi_pkg;

  localparam logic ADR_TXDATA = 1'b0;
  localparam logic ADR_STATUS = 1'b1;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_LVL_LSB = 4;

  typedef enum logic {
    EXP_IDLE     = 1'b0,
    EXP_WAIT_ACK = 1'b1
  } export_state_e;

  function automatic logic [7:0] status_byte(input logic [3:0] level,
                                             input logic       ovf,
                                             input logic       full,
                                             input logic       empty);
    logic [7:0] s;
    s                   = 8'h00;
    s[ST_LVL_LSB +: 4]  = level;
    s[ST_OVF]           = ovf;
    s[ST_FULL]          = full;
    s[ST_EMPTY]         = empty;
    return s;
  endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock FIFO with show-ahead head output and an occupancy counter.
module fifo_sync #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LW'(DEPTH));
  assign empty    = (level == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/spi_tx_feeder.sv
// Wishbone-classic slave that queues bytes and exports them one at a time to
// the SPI clock domain through a toggle request/acknowledge handshake.
module spi_tx_feeder
  import spi_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wb_cyc,
  input  logic          wb_stb,
  input  logic          wb_we,
  input  logic          wb_adr,
  input  logic [7:0]    wb_dat_i,
  output logic [7:0]    wb_dat_o,
  output logic          wb_ack,
  output logic [7:0]    cdc_data,
  output logic          cdc_req,
  input  logic          cdc_ack,
  output export_state_e dbg_state
);

  localparam int LW = $clog2(DEPTH + 1);

  // Handshake: a new byte is offered by toggling cdc_req with cdc_data stable;
  // the SPI side accepts it by making cdc_ack equal to cdc_req. Only then may
  // cdc_data change again.

  logic          wb_req;
  logic          wr_tx;
  logic          rd_status;
  logic          overflow;
  logic          ack_meta;
  logic          ack_s;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_head;
  logic [7:0]    status;
  logic          load;
  export_state_e state, state_nxt;

  assign wb_req    = wb_cyc & wb_stb & ~wb_ack;
  assign wr_tx     = wb_ack & wb_cyc & wb_stb & wb_we & (wb_adr == ADR_TXDATA);
  assign rd_status = wb_ack & wb_cyc & wb_stb & ~wb_we & (wb_adr == ADR_STATUS);
  assign fifo_push = wr_tx & ~fifo_full;
  assign status    = status_byte(4'(fifo_level), overflow, fifo_full, fifo_empty);
  assign dbg_state = state;

  fifo_sync #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (wb_dat_i),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Read data is registered in the request cycle so it is valid with wb_ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ack   <= 1'b0;
      wb_dat_o <= 8'h00;
    end else begin
      wb_ack   <= wb_req;
      wb_dat_o <= (wb_req & ~wb_we & (wb_adr == ADR_STATUS)) ? status : 8'h00;
    end
  end

  // A fresh overflow wins over the read-to-clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  overflow <= 1'b0;
    else if (wr_tx & fifo_full)  overflow <= 1'b1;
    else if (rd_status)          overflow <= 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_meta <= 1'b0;
      ack_s    <= 1'b0;
    end else begin
      ack_meta <= cdc_ack;
      ack_s    <= ack_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= EXP_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fifo_pop  = 1'b0;
    case (state)
      EXP_IDLE: begin
        if (!fifo_empty) begin
          load      = 1'b1;
          fifo_pop  = 1'b1;
          state_nxt = EXP_WAIT_ACK;
        end
      end
      EXP_WAIT_ACK: begin
        if (ack_s == cdc_req) state_nxt = EXP_IDLE;
      end
      default: state_nxt = EXP_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdc_data <= 8'h00;
      cdc_req  <= 1'b0;
    end else if (load) begin
      cdc_data <= fifo_head;
      cdc_req  <= ~cdc_req;
    end
  end

endmodule

// File: tb/tb_spi_tx_feeder.sv
// Directed bench: a DEPTH=4 feeder for the register/handshake scenarios and a
// DEPTH=8 feeder for ordering across pointer wrap with random ack delays.
module tb_spi_tx_feeder;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       wb_stb, wb_we, wb_adr;
  logic [7:0] wb_dat_i;
  logic       cyc4, cyc8;

  logic [7:0]    dat_o4, cdc_data4, dat_o8, cdc_data8;
  logic          ack4, cdc_req4, cdc_ack4, ack8, cdc_req8, cdc_ack8;
  export_state_e st4, st8;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  spi_tx_feeder #(.DEPTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc4), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat_o4), .wb_ack(ack4),
    .cdc_data(cdc_data4), .cdc_req(cdc_req4), .cdc_ack(cdc_ack4), .dbg_state(st4)
  );

  spi_tx_feeder #(.DEPTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc8), .wb_stb(wb_stb), .wb_we(wb_we),
    .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(dat_o8), .wb_ack(ack8),
    .cdc_data(cdc_data8), .cdc_req(cdc_req8), .cdc_ack(cdc_ack8), .dbg_state(st8)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Classic cycle: hold controls until the ack edge, then release.
  task automatic wb_cycle(input bit sel, input bit we, input logic adr,
                          input logic [7:0] din, output logic [7:0] dout);
    bit got;
    got  = 1'b0;
    dout = 8'h00;
    @(negedge clk);
    wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = din;
    if (sel) cyc8 = 1'b1; else cyc4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if ((sel ? ack8 : ack4) === 1'b1) begin
        got  = 1'b1;
        dout = sel ? dat_o8 : dat_o4;
        break;
      end
    end
    if (!got) check("wb_ack_timeout", 8'h00, 8'h01);
    @(posedge clk);
    #1;
    wb_stb = 1'b0; wb_we = 1'b0; cyc4 = 1'b0; cyc8 = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic [7:0] exp_b;
    bit         ok;

    rst_n = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = 1'b0; wb_dat_i = 8'h00;
    cyc4 = 1'b0; cyc8 = 1'b0; cdc_ack4 = 1'b0; cdc_ack8 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack", {7'b0, ack4}, 8'h00);
    check("rst_dat_o", dat_o4, 8'h00);
    check("rst_cdc_data", cdc_data4, 8'h00);
    check("rst_cdc_req", {7'b0, cdc_req4}, 8'h00);
    check("rst_state", 8'(st4), 8'(EXP_IDLE));
    rst_n = 1'b1;

    // Single byte with an acking SPI side; cdc_req toggles 2 cycles after ack.
    wb_cycle(0, 1, ADR_TXDATA, 8'hA5, rd);
    @(negedge clk);
    check("lat_req_not_yet", {7'b0, cdc_req4}, 8'h00);
    @(negedge clk);
    check("lat_req_toggled", {7'b0, cdc_req4}, 8'h01);
    check("a5_data", cdc_data4, 8'hA5);
    check("a5_wait_state", 8'(st4), 8'(EXP_WAIT_ACK));
    cdc_ack4 = 1'b1;
    @(negedge clk);
    check("a5_still_wait", 8'(st4), 8'(EXP_WAIT_ACK));
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (st4 == EXP_IDLE) begin ok = 1'b1; break; end
    end
    check("a5_back_idle", {7'b0, ok}, 8'h01);

    // Ack held: 01 exported, 02..05 fill the FIFO.
    for (int i = 1; i <= 5; i++) wb_cycle(0, 1, ADR_TXDATA, 8'(i), rd);
    check("fill_data", cdc_data4, 8'h01);
    check("fill_req", {7'b0, cdc_req4}, 8'h00);
    wb_cycle(0, 0, ADR_STATUS, 8'h00, rd);
    check("status_full", rd, 8'h42);
    wb_cycle(0, 0, ADR_TXDATA, 8'h00, rd);
    check("txdata_read_zero", rd, 8'h00);

    // Overflow drops 06, is sticky, and clears on read.
    wb_cycle(0, 1, ADR_TXDATA, 8'h06, rd);
    wb_cycle(0, 1, ADR_STATUS, 8'hFF, rd);
    wb_cycle(0, 0, ADR_STATUS, 8'h00, rd);
    check("status_ovf_set", rd, 8'h46);
    wb_cycle(0, 0, ADR_STATUS, 8'h00, rd);
    check("status_ovf_clr", rd, 8'h42);

    // Drain: 02..05 in order.
    for (int n = 2; n <= 5; n++) begin
      cdc_ack4 = cdc_req4;
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        if (cdc_req4 !== cdc_ack4) begin ok = 1'b1; break; end
      end
      check("drain_toggle", {7'b0, ok}, 8'h01);
      exp_b = 8'(n);
      check("drain_data", cdc_data4, exp_b);
    end
    cdc_ack4 = cdc_req4;
    repeat (12) @(negedge clk);
    check("no_06_export", {7'b0, cdc_req4}, {7'b0, cdc_ack4});
    check("drain_idle", 8'(st4), 8'(EXP_IDLE));
    wb_cycle(0, 0, ADR_STATUS, 8'h00, rd);
    check("status_empty", rd, 8'h01);

    // Reset while waiting for ack with 3 bytes queued.
    for (int i = 0; i < 4; i++) wb_cycle(0, 1, ADR_TXDATA, 8'h11 + 8'(i), rd);
    check("pre_rst_state", 8'(st4), 8'(EXP_WAIT_ACK));
    wb_cycle(0, 0, ADR_STATUS, 8'h00, rd);
    check("pre_rst_level3", rd, 8'h30);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cdc_ack4 = 1'b0;
    #1;
    check("mid_rst_cdc_req", {7'b0, cdc_req4}, 8'h00);
    check("mid_rst_cdc_data", cdc_data4, 8'h00);
    check("mid_rst_dat_o", dat_o4, 8'h00);
    check("mid_rst_ack", {7'b0, ack4}, 8'h00);
    check("mid_rst_state", 8'(st4), 8'(EXP_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_no_toggle", {7'b0, cdc_req4}, 8'h00);
    wb_cycle(0, 0, ADR_STATUS, 8'h00, rd);
    check("post_rst_status", rd, 8'h01);

    // DEPTH=8: 20 bytes through the wrap with random ack delays.
    fork
      begin : writer
        logic [7:0] s;
        logic [7:0] d;
        for (int i = 0; i < 20; i++) begin
          for (int t = 0; t < 100; t++) begin
            wb_cycle(1, 0, ADR_STATUS, 8'h00, s);
            if (!s[ST_FULL]) break;
            repeat (3) @(negedge clk);
          end
          wb_cycle(1, 1, ADR_TXDATA, 8'hC0 + 8'(i), d);
          exp_q.push_back(8'hC0 + 8'(i));
        end
      end
      begin : reader
        bit seen;
        for (int n = 0; n < 20; n++) begin
          seen = 1'b0;
          for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (cdc_req8 !== cdc_ack8) begin seen = 1'b1; break; end
          end
          if (!seen) begin
            check("wrap_timeout", 8'h00, 8'h01);
            break;
          end
          if (exp_q.size() == 0) check("wrap_unexpected", cdc_data8, 8'hFF);
          else                   check("wrap_order", cdc_data8, exp_q.pop_front());
          repeat ($urandom_range(0, 5)) @(negedge clk);
          cdc_ack8 = cdc_req8;
        end
      end
    join
    repeat (8) @(negedge clk);
    check("wrap_idle", 8'(st8), 8'(EXP_IDLE));
    check("wrap_queue_empty", 8'(exp_q.size()), 8'h00);
    wb_cycle(1, 0, ADR_STATUS, 8'h00, rd);
    check("wrap_status", rd, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_tx_feeder.md
SPI_TX_FEEDER -- requirements
Module: spi_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries (power of two, 2..16).
REQ-002 SHALL have port clk  in  1  Wishbone-domain clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have ports wb_cyc, wb_stb, wb_we  in  1 each  Wishbone classic slave controls.
REQ-005 SHALL have port wb_adr  in  1  register select: 0 = TXDATA, 1 = STATUS.
REQ-006 SHALL have port wb_dat_i  in  8  write data.
REQ-007 SHALL have port wb_dat_o  out  8  read data.
REQ-008 SHALL have port wb_ack  out  1  single-cycle acknowledge.
REQ-009 SHALL have port cdc_data  out  8  byte exported to the SPI clock domain; stable while a request is pending.
REQ-010 SHALL have port cdc_req  out  1  toggle: each transition offers a new cdc_data.
REQ-011 SHALL have port cdc_ack  in  1  toggle from the SPI domain, asynchronous to clk.

Function
REQ-012 SHALL assert wb_ack exactly one cycle after a cycle with wb_cyc&wb_stb&!wb_ack, for one cycle; back-to-back requests are therefore acked on alternate cycles.
REQ-013 SHALL perform register side effects only in the cycle wb_ack is asserted.
REQ-014 A TXDATA write SHALL push wb_dat_i when the FIFO is not full at that cycle; otherwise the byte is dropped and sticky overflow is set.
REQ-015 A pop in the same cycle as a write to a full FIFO SHALL NOT make room for that write (no pass-through).
REQ-016 A STATUS read SHALL return {level[3:0], 1'b0, overflow, full, empty} and clear overflow in the same cycle; if a new overflow occurs in that cycle, overflow SHALL remain set.
REQ-017 A TXDATA read SHALL return 8'h00 with no side effect; STATUS writes SHALL be ignored.
REQ-018 SHALL pass cdc_ack through a 2-flop synchronizer (ack_s) before any use.
REQ-019 SHALL implement export FSM IDLE/WAIT_ACK: IDLE with FIFO non-empty -> load head into cdc_data, toggle cdc_req, pop, enter WAIT_ACK.
REQ-020 In WAIT_ACK, SHALL return to IDLE on the first cycle ack_s == cdc_req.
REQ-021 With the FIFO empty in IDLE, SHALL hold cdc_data and cdc_req unchanged.
REQ-022 level SHALL count 0..DEPTH; pointers are log2(DEPTH) bits and wrap modulo DEPTH; simultaneous push and pop leaves level unchanged.
REQ-023 Latency from a TXDATA write ack, with FIFO empty and FSM IDLE, to cdc_req toggle SHALL be 2 cycles.

Reset
REQ-024 On rst_n low, SHALL clear wb_ack, wb_dat_o, cdc_data (8'h00), cdc_req, both synchronizer flops, FIFO pointers, level and overflow, and enter IDLE.
REQ-025 Reset mid-transfer SHALL discard FIFO contents and any pending request; the SPI side is reset with the same rst_n.

Structure
REQ-026 Register addresses, STATUS bit positions and FSM state enum SHALL live in shared package spi_pkg.
REQ-027 FIFO storage and pointers SHALL be sub-module fifo_sync (parameter DEPTH, width 8, push/pop/full/empty/level).

Verification
REQ-028 Write 8'hA5 to TXDATA with an acking SPI model -> cdc_data=8'hA5, cdc_req toggles 2 cycles after wb_ack, FSM returns to IDLE after ack_s matches.
REQ-029 Hold cdc_ack constant, write 5 bytes 01..05 -> 01 exported; 02..05 fill FIFO; STATUS = level 4, full=1, overflow=0.
REQ-030 Continue from REQ-029, write 8'h06 -> dropped, STATUS read returns overflow=1; second read returns overflow=0.
REQ-031 Release cdc_ack toggling -> bytes 02,03,04,05 exported in order, never 06; STATUS ends empty=1, level 0.
REQ-032 Assert rst_n low while WAIT_ACK with 3 bytes queued -> all outputs zero, STATUS empty=1, no further cdc_req toggles.
REQ-033 DEPTH=8: push/pop 20 bytes with random ack delays -> output sequence equals input sequence across pointer wrap.
